// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
// Shared types and constants for the MIPS32 execution core.
//   - DATA_W / NREGS / REG_AW : fixed datapath geometry (32 x 32-bit, 5-bit index)
//   - aluop_t                 : ALU operation codes driven by the control FSM
//   - REG_ZERO / REG_V0 / REG_RA : architecturally special register indices
// Optional build macro: MIPS_CPU_ALU_SLTU_EN adds ALU_SLTU (opcode 13).
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

   localparam int DATA_W = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = 5;

   typedef enum logic [4:0] {
      ALU_AND  = 5'd0,
      ALU_OR   = 5'd1,
      ALU_ADD  = 5'd2,
      ALU_SUB  = 5'd3,
      ALU_SLT  = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_SLL  = 5'd6,
      ALU_SRL  = 5'd7,
      ALU_SRA  = 5'd8,
      ALU_SLLV = 5'd9,
      ALU_SRLV = 5'd10,
      ALU_SRAV = 5'd11,
`ifdef MIPS_CPU_ALU_SLTU_EN
      ALU_LUI  = 5'd12,
      ALU_SLTU = 5'd13
`else
      ALU_LUI  = 5'd12
`endif
   } aluop_t;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_AW-1:0] REG_V0   = 5'd2;
   localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/mips_cpu_alu_unit.sv
// ---------------------------------------------------------------------------
// mips_cpu_alu_unit
// Purely combinational MIPS32 ALU. All arithmetic wraps mod 2^32.
// Ports:
//   alu_op     in  5   operation code (aluop_t values)
//   alu_a      in  32  operand A (rs); a[4:0] is the variable shift amount
//   alu_b      in  32  operand B (rt or sign-extended immediate); shift source
//   alu_sa     in  5   constant shift amount (instr[10:6])
//   alu_result out 32  result; 0 for unlisted opcodes
//   alu_zero   out 1   alu_result == 0
// Optional build macro: MIPS_CPU_ALU_SLTU_EN enables SLTU on opcode 13.
// ---------------------------------------------------------------------------
module mips_cpu_alu_unit
   import mips_cpu_pkg::*;
(
   input  logic [4:0]        alu_op,
   input  logic [DATA_W-1:0] alu_a,
   input  logic [DATA_W-1:0] alu_b,
   input  logic [4:0]        alu_sa,
   output logic [DATA_W-1:0] alu_result,
   output logic              alu_zero
);

   always_comb begin
      // NOTE: default assignment first so every path drives alu_result and no latch is inferred.
      alu_result = '0;
      case (alu_op)
         ALU_AND:  alu_result = alu_a & alu_b;
         ALU_OR:   alu_result = alu_a | alu_b;
         ALU_ADD:  alu_result = alu_a + alu_b;
         ALU_SUB:  alu_result = alu_a - alu_b;
         ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         ALU_XOR:  alu_result = alu_a ^ alu_b;
         ALU_SLL:  alu_result = alu_b << alu_sa;
         ALU_SRL:  alu_result = alu_b >> alu_sa;
         // Arithmetic shifts need a signed operand, otherwise >>> fills with zeros.
         ALU_SRA:  alu_result = $unsigned($signed(alu_b) >>> alu_sa);
         ALU_SLLV: alu_result = alu_b << alu_a[4:0];
         ALU_SRLV: alu_result = alu_b >> alu_a[4:0];
         ALU_SRAV: alu_result = $unsigned($signed(alu_b) >>> alu_a[4:0]);
         ALU_LUI:  alu_result = {alu_b[15:0], 16'h0000};
`ifdef MIPS_CPU_ALU_SLTU_EN
         ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
`endif
         default:  alu_result = '0;
      endcase
   end

   assign alu_zero = (alu_result == '0);

endmodule

// File: rtl/mips_cpu_regfile_alu.sv
// ---------------------------------------------------------------------------
// mips_cpu_regfile_alu
// Execution core of the multicycle MIPS32 CPU: 32x32 register file with two
// combinational read ports and one synchronous write port, plus the ALU.
// Ports:
//   clk, reset                 rising-edge clock; async active-high reset clears all registers
//   wr_en, wr_addr, wr_data    write port (writes to r0 discarded, ignored during reset)
//   rd_addr_a/rd_data_a        read port A (rs), zero latency, no write bypass
//   rd_addr_b/rd_data_b        read port B (rt), zero latency, no write bypass
//   register_v0                continuous view of r2
//   alu_op, alu_a, alu_b, alu_sa, alu_result, alu_zero : see mips_cpu_alu_unit
// Optional build macro: MIPS_CPU_ALU_SLTU_EN (SLTU opcode in the ALU).
// ---------------------------------------------------------------------------
module mips_cpu_regfile_alu
   import mips_cpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [31:0]       wr_data,
   input  logic [4:0]        rd_addr_a,
   output logic [31:0]       rd_data_a,
   input  logic [4:0]        rd_addr_b,
   output logic [31:0]       rd_data_b,
   output logic [31:0]       register_v0,
   input  logic [4:0]        alu_op,
   input  logic [31:0]       alu_a,
   input  logic [31:0]       alu_b,
   input  logic [4:0]        alu_sa,
   output logic [31:0]       alu_result,
   output logic              alu_zero
);

   logic [DATA_W-1:0] regs [NREGS];

   // NOTE: this array has an async reset, so it builds as flip-flops rather than RAM; clearing on reset is part of the architecture here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != REG_ZERO)) begin
         // NOTE: non-blocking so same-edge readers of regs see the pre-write value.
         regs[wr_addr] <= wr_data;
      end
   end

   // r0 is hard-wired to zero on the read side as well, so it never depends on reset having run.
   assign rd_data_a   = (rd_addr_a == REG_ZERO) ? '0 : regs[rd_addr_a];
   assign rd_data_b   = (rd_addr_b == REG_ZERO) ? '0 : regs[rd_addr_b];
   assign register_v0 = regs[REG_V0];

   mips_cpu_alu_unit u_alu (
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sa     (alu_sa),
      .alu_result (alu_result),
      .alu_zero   (alu_zero)
   );

endmodule

// File: tb/tb_mips_cpu_regfile_alu.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_regfile_alu
// Self-checking bench for mips_cpu_regfile_alu. Expected values are queued
// when stimulus is applied and compared once the outputs have settled.
// ---------------------------------------------------------------------------
module tb_mips_cpu_regfile_alu;
   import mips_cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr_a;
   logic [31:0] rd_data_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_b;
   logic [31:0] register_v0;
   logic [4:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_sa;
   logic [31:0] alu_result;
   logic        alu_zero;

   always #5 clk = ~clk;

   mips_cpu_regfile_alu dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr_a   (rd_addr_a),
      .rd_data_a   (rd_data_a),
      .rd_addr_b   (rd_addr_b),
      .rd_data_b   (rd_data_b),
      .register_v0 (register_v0),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sa      (alu_sa),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero)
   );

   typedef enum int {OUT_RDA, OUT_RDB, OUT_V0, OUT_RES, OUT_ZERO} out_sel_t;

   typedef struct {
      string       tag;
      out_sel_t    sel;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t    sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model [32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input out_sel_t sel, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.sel = sel;
      it.exp = exp;
      sb.push_back(it);
   endtask

   // Let combinational outputs settle, then compare every queued expectation.
   task automatic drain();
      sb_item_t    it;
      logic [31:0] got;
      #1;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         case (it.sel)
            OUT_RDA:  got = rd_data_a;
            OUT_RDB:  got = rd_data_b;
            OUT_V0:   got = register_v0;
            OUT_RES:  got = alu_result;
            default:  got = {31'd0, alu_zero};
         endcase
         check(it.tag, got, it.exp);
      end
   endtask

   task automatic reg_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      @(posedge clk);
      if (!reset && addr != 5'd0) model[addr] = data;
      #1;
      wr_en = 1'b0;
   endtask

   task automatic alu_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sa, input logic [31:0] exp);
      @(negedge clk);
      alu_op = op;
      alu_a  = a;
      alu_b  = b;
      alu_sa = sa;
      push({tag, ".res"}, OUT_RES, exp);
      push({tag, ".zero"}, OUT_ZERO, {31'd0, (exp == 32'd0)});
      drain();
   endtask

   initial begin
      logic [4:0]  ra;
      logic [31:0] rv;
      for (int i = 0; i < 32; i++) model[i] = '0;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = 5'd2; rd_addr_b = 5'd31;
      alu_op = '0; alu_a = '0; alu_b = '0; alu_sa = '0;

      // Reset state
      push("rst.rda", OUT_RDA, 32'd0);
      push("rst.rdb", OUT_RDB, 32'd0);
      push("rst.v0", OUT_V0, 32'd0);
      drain();
      @(negedge clk);
      reset = 1'b0;

      // Async reset mid-cycle clears r5 before the next edge
      reg_write(5'd5, 32'hDEADBEEF);
      @(negedge clk);
      rd_addr_a = 5'd5;
      push("r5.written", OUT_RDA, 32'hDEADBEEF);
      drain();
      reset = 1'b1;
      for (int i = 0; i < 32; i++) model[i] = '0;
      push("r5.async_rst", OUT_RDA, 32'd0);
      drain();

      // Writes ignored while reset is high
      reg_write(5'd6, 32'hA5A5A5A5);
      @(negedge clk);
      reset = 1'b0;
      rd_addr_b = 5'd6;
      push("r6.wr_in_rst", OUT_RDB, 32'd0);
      drain();

      // r0 discards writes
      reg_write(5'd0, 32'h00001234);
      @(negedge clk);
      rd_addr_a = 5'd0;
      push("r0.read", OUT_RDA, 32'd0);
      drain();

      // Read-during-write returns old value, then v0 and dual-port read
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h7;
      rd_addr_a = 5'd2; rd_addr_b = 5'd2;
      push("r2.rdw_old", OUT_RDA, 32'd0);
      push("v0.before", OUT_V0, 32'd0);
      drain();
      @(posedge clk);
      model[2] = 32'h7;
      #1;
      wr_en = 1'b0;
      push("v0.after", OUT_V0, 32'h7);
      push("r2.port_a", OUT_RDA, 32'h7);
      push("r2.port_b", OUT_RDB, 32'h7);
      drain();

      // Random writes, then read back every register on both ports
      for (int i = 0; i < 10; i++) begin
         ra = 5'($urandom_range(1, 31));
         rv = $urandom;
         reg_write(ra, rv);
      end
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rd_addr_a = 5'(i);
         rd_addr_b = 5'(31 - i);
         push($sformatf("rand.a.r%0d", i), OUT_RDA, model[i]);
         push($sformatf("rand.b.r%0d", 31 - i), OUT_RDB, model[31 - i]);
         drain();
      end
      push("rand.v0", OUT_V0, model[2]);
      drain();

      // ALU
      alu_vec("add.wrap",  ALU_ADD,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0);
      alu_vec("add.plain", ALU_ADD,  32'h12345678, 32'h11111111, 5'd0,  32'h23456789);
      alu_vec("sub.neg",   ALU_SUB,  32'd3,        32'd5,        5'd0,  32'hFFFFFFFE);
      alu_vec("slt.neg",   ALU_SLT,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1);
      alu_vec("slt.pos",   ALU_SLT,  32'h1,        32'hFFFFFFFF, 5'd0,  32'h0);
      alu_vec("and",       ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000);
      alu_vec("or",        ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0);
      alu_vec("xor",       ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0);
      alu_vec("lui",       ALU_LUI,  32'h0,        32'hFFFF1234, 5'd0,  32'h12340000);
      alu_vec("sra",       ALU_SRA,  32'h0,        32'h80000000, 5'd4,  32'hF8000000);
      alu_vec("srl",       ALU_SRL,  32'h0,        32'h80000000, 5'd4,  32'h08000000);
      alu_vec("sll",       ALU_SLL,  32'h0,        32'h1,        5'd31, 32'h80000000);
      alu_vec("sll.zero",  ALU_SLL,  32'h0,        32'hCAFEF00D, 5'd0,  32'hCAFEF00D);
      alu_vec("sllv",      ALU_SLLV, 32'h00000024, 32'h1,        5'd9,  32'h10);
      alu_vec("srav",      ALU_SRAV, 32'hFFFFFFE8, 32'h80000000, 5'd4,  32'hFF800000);
      alu_vec("srlv",      ALU_SRLV, 32'h00000004, 32'h80000000, 5'd0,  32'h08000000);
      alu_vec("srlv.a0",   ALU_SRLV, 32'h00000020, 32'h80000001, 5'd3,  32'h80000001);
`ifdef MIPS_CPU_ALU_SLTU_EN
      alu_vec("op13",      5'd13,    32'h1,        32'hFFFFFFFF, 5'd0,  32'h1);
`else
      alu_vec("op13",      5'd13,    32'h1,        32'hFFFFFFFF, 5'd0,  32'h0);
`endif
      alu_vec("op20",      5'd20,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h0);
      alu_vec("op31",      5'd31,    32'h12345678, 32'h9ABCDEF0, 5'd1,  32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
